// File: rtl/mem_arb_pkg.sv
// Shared types, segment constants and the VA->PA helper for the memory bus arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INST = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic {
        GNT_INST = 1'b0,
        GNT_DATA = 1'b1
    } grant_t;

    // Transfer attributes latched at grant and presented on the memory port.
    typedef struct packed {
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        uncached;
    } xfer_t;

    localparam logic [2:0] KSEG1_TOP    = 3'b101;
    localparam logic [1:0] UNMAPPED_TOP = 2'b10;

    // kseg0/kseg1 are direct-mapped windows onto the low 512 MB.
    function automatic logic [31:0] seg_to_phys(input logic [31:0] va);
        if (va[31:30] == UNMAPPED_TOP) begin
            return {3'b000, va[28:0]};
        end
        return va;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of requester (fetch/data) and memory-port signals around the arbiter.
interface mem_bus_arbiter_if;

    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_ack;
    logic        inst_err;

    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_ack;
    logic        data_err;

    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_uncached;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    // Arbiter view.
    modport slave (
        input  inst_req, inst_addr,
        output inst_rdata, inst_ack, inst_err,
        input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
        output data_rdata, data_ack, data_err,
        output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata, mem_uncached,
        input  mem_rdata, mem_ready
    );

    // Core pipeline plus memory view.
    modport master (
        output inst_req, inst_addr,
        input  inst_rdata, inst_ack, inst_err,
        output data_req, data_wr, data_wstrb, data_addr, data_wdata,
        input  data_rdata, data_ack, data_err,
        input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata, mem_uncached,
        output mem_rdata, mem_ready
    );

endinterface

// File: rtl/mem_bus_arbiter_seg_xlate.sv
// Combinational segment translation: VA -> {PA, uncached}.
module seg_xlate
    import mem_arb_pkg::*;
(
    input  logic [31:0] va,
    output logic [31:0] pa,
    output logic        uncached
);

    assign pa       = seg_to_phys(va);
    assign uncached = (va[31:29] == KSEG1_TOP);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Fetch/data arbiter onto a single memory port with segment translation and wait watchdog.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed data-over-fetch priority.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 255
)(
    input  logic              clk,
    input  logic              resetn,
    mem_bus_arbiter_if.slave  bus
);

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      state;
    state_t      state_nx;
    grant_t      last_grant;
    xfer_t       xfer_q;
    logic [7:0]  wait_cnt;
    logic        err_q;
    logic [31:0] inst_rdata_q;
    logic [31:0] data_rdata_q;

    logic        any_req;
    logic        pick_data;
    logic        timeout;
    logic [31:0] sel_va;
    logic [31:0] sel_pa;
    logic        sel_uncached;

    assign any_req = bus.inst_req | bus.data_req;

`ifdef ARB_ROUND_ROBIN_EN
    assign pick_data = bus.data_req & (~bus.inst_req | (last_grant == GNT_INST));
`else
    assign pick_data = bus.data_req;
`endif

    assign sel_va  = pick_data ? bus.data_addr : bus.inst_addr;
    assign timeout = (wait_cnt == WAIT_LAST);

    seg_xlate u_seg_xlate (
        .va       (sel_va),
        .pa       (sel_pa),
        .uncached (sel_uncached)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: default assignment first so no path through the case leaves state_nx unassigned (no latch).
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:       if (any_req) state_nx = pick_data ? DATA : INST;
            INST, DATA: if (bus.mem_ready || timeout) state_nx = DONE;
            DONE:       state_nx = IDLE;
            default:    state_nx = IDLE;
        endcase
    end

    // NOTE: datapath registers are reset as well, because every output must read 0 out of reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant   <= GNT_INST;
            xfer_q       <= '0;
            wait_cnt     <= '0;
            err_q        <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        last_grant      <= pick_data ? GNT_DATA : GNT_INST;
                        xfer_q.addr     <= sel_pa;
                        xfer_q.uncached <= sel_uncached;
                        xfer_q.wr       <= pick_data & bus.data_wr;
                        xfer_q.wstrb    <= pick_data ? bus.data_wstrb : 4'b0000;
                        xfer_q.wdata    <= pick_data ? bus.data_wdata : 32'h0;
                        wait_cnt        <= '0;
                        err_q           <= 1'b0;
                    end
                end
                INST, DATA: begin
                    if (bus.mem_ready) begin
                        if (state == INST) inst_rdata_q <= bus.mem_rdata;
                        else               data_rdata_q <= bus.mem_rdata;
                    end else if (timeout) begin
                        // Watchdog abort: return zero data and flag the error on the ack.
                        if (state == INST) inst_rdata_q <= 32'h0;
                        else               data_rdata_q <= 32'h0;
                        err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.mem_req  = 1'b0;
        bus.inst_ack = 1'b0;
        bus.inst_err = 1'b0;
        bus.data_ack = 1'b0;
        bus.data_err = 1'b0;
        case (state)
            INST, DATA: bus.mem_req = 1'b1;
            DONE: begin
                bus.inst_ack = (last_grant == GNT_INST);
                bus.inst_err = (last_grant == GNT_INST) & err_q;
                bus.data_ack = (last_grant == GNT_DATA);
                bus.data_err = (last_grant == GNT_DATA) & err_q;
            end
            default: ;
        endcase
    end

    assign bus.mem_wr       = xfer_q.wr;
    assign bus.mem_wstrb    = xfer_q.wstrb;
    assign bus.mem_addr     = xfer_q.addr;
    assign bus.mem_wdata    = xfer_q.wdata;
    assign bus.mem_uncached = xfer_q.uncached;
    assign bus.inst_rdata   = inst_rdata_q;
    assign bus.data_rdata   = data_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed cases plus randomized rounds against a transaction model.
module tb_mem_bus_arbiter;

    localparam int MAX_WAIT = 8;

    logic clk;
    logic resetn;
    int   checks;
    int   errors;

    logic [31:0] exp_inst_rdata;
    logic [31:0] exp_data_rdata;
`ifdef ARB_ROUND_ROBIN_EN
    bit          last_was_data;
`endif

    mem_bus_arbiter_if bus ();

    mem_bus_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_pa(input logic [31:0] va);
        return (va[31:30] == 2'b10) ? (va & 32'h1FFF_FFFF) : va;
    endfunction

    // One arbitration round, started at a negedge while the DUT is idle; ends at the idle-cycle negedge.
    task automatic run_round(input logic ireq, input logic [31:0] iaddr,
                             input logic dreq, input logic dwr, input logic [3:0] dstrb,
                             input logic [31:0] daddr, input logic [31:0] dwdata,
                             input int delay);
        logic        win_data;
        logic [31:0] va;
        logic [31:0] rd;
        logic [31:0] exp_rd;
        int          high_cnt;
        int          exp_cnt;
        bit          exp_err;
        bit          fin;

        bus.inst_req   = ireq;
        bus.inst_addr  = iaddr;
        bus.data_req   = dreq;
        bus.data_wr    = dwr;
        bus.data_wstrb = dstrb;
        bus.data_addr  = daddr;
        bus.data_wdata = dwdata;

`ifdef ARB_ROUND_ROBIN_EN
        win_data      = dreq && (!ireq || !last_was_data);
        last_was_data = win_data;
`else
        win_data = dreq;
`endif
        va      = win_data ? daddr : iaddr;
        exp_err = (delay >= MAX_WAIT);
        exp_cnt = exp_err ? MAX_WAIT : delay + 1;
        rd      = $urandom;
        exp_rd  = exp_err ? 32'h0 : rd;

        @(posedge clk);
        high_cnt = 0;
        fin      = 1'b0;
        for (int c = 0; c < 40 && !fin; c++) begin
            @(negedge clk);
            if (bus.mem_req === 1'b1) begin
                if (high_cnt == 0) begin
                    check("mem_addr", bus.mem_addr, exp_pa(va));
                    check("mem_uncached", {31'h0, bus.mem_uncached}, {31'h0, va[31:29] == 3'b101});
                    check("mem_wr", {31'h0, bus.mem_wr}, {31'h0, win_data & dwr});
                    check("mem_wstrb", {28'h0, bus.mem_wstrb}, {28'h0, win_data ? dstrb : 4'b0000});
                    check("mem_wdata", bus.mem_wdata, win_data ? dwdata : 32'h0);
                end
                bus.mem_ready = (high_cnt == delay);
                bus.mem_rdata = (high_cnt == delay) ? rd : $urandom;
                high_cnt++;
            end else begin
                fin = 1'b1;
            end
        end
        bus.mem_ready = 1'b0;

        if (win_data) exp_data_rdata = exp_rd;
        else          exp_inst_rdata = exp_rd;

        check("done_reached", {31'h0, fin}, 32'h1);
        check("mem_req_cycles", high_cnt, exp_cnt);
        check("inst_ack", {31'h0, bus.inst_ack}, {31'h0, !win_data});
        check("data_ack", {31'h0, bus.data_ack}, {31'h0, win_data});
        check("inst_err", {31'h0, bus.inst_err}, {31'h0, !win_data && exp_err});
        check("data_err", {31'h0, bus.data_err}, {31'h0, win_data && exp_err});
        check("inst_rdata", bus.inst_rdata, exp_inst_rdata);
        check("data_rdata", bus.data_rdata, exp_data_rdata);

        @(posedge clk);
        #1;
        bus.inst_req = 1'b0;
        bus.data_req = 1'b0;
        @(negedge clk);
        check("idle_acks", {30'h0, bus.inst_ack, bus.data_ack}, 32'h0);
        check("idle_mem_req", {31'h0, bus.mem_req}, 32'h0);
    endtask

    initial begin
        logic [1:0] r;
        checks         = 0;
        errors         = 0;
        exp_inst_rdata = 32'h0;
        exp_data_rdata = 32'h0;
`ifdef ARB_ROUND_ROBIN_EN
        last_was_data  = 1'b0;
`endif
        resetn         = 1'b0;
        bus.inst_req   = 1'b0;
        bus.inst_addr  = 32'h0;
        bus.data_req   = 1'b0;
        bus.data_wr    = 1'b0;
        bus.data_wstrb = 4'h0;
        bus.data_addr  = 32'h0;
        bus.data_wdata = 32'h0;
        bus.mem_rdata  = 32'h0;
        bus.mem_ready  = 1'b0;

        @(negedge clk);
        check("rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
        check("rst_acks", {28'h0, bus.inst_ack, bus.inst_err, bus.data_ack, bus.data_err}, 32'h0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_mem_attr", {25'h0, bus.mem_wr, bus.mem_wstrb, bus.mem_uncached}, 32'h0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        check("rst_inst_rdata", bus.inst_rdata, 32'h0);
        check("rst_data_rdata", bus.data_rdata, 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        // Directed: kseg1 fetch, kseg0 write, kseg2 and kuseg pass-through.
        run_round(1'b1, 32'hBFC0_0000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 2);
        run_round(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h8000_1004, 32'hCAFE_F00D, 1);
        run_round(1'b1, 32'hC000_0010, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 0);
        run_round(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h0040_0000, 32'h1234_5678, 3);

        // Fetch issued while a write is pending must not write.
        run_round(1'b1, 32'h0040_0100, 1'b0, 1'b1, 4'hF, 32'h8000_0000, 32'hFFFF_FFFF, 0);

        // Both requesters held high across rounds.
        for (int i = 0; i < 4; i++) begin
            run_round(1'b1, 32'h0000_1000 + 32'(i), 1'b1, 1'b0, 4'h0, 32'h0000_2000 + 32'(i), 32'h0, 1);
        end

        // Watchdog: mem_ready never arrives; ready on the last allowed cycle still succeeds.
        run_round(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h8000_0040, 32'h0, 100);
        run_round(1'b1, 32'hA000_0080, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 100);
        run_round(1'b1, 32'h0000_0080, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, MAX_WAIT - 1);

        // Asynchronous reset in the middle of a data transfer.
        bus.data_req  = 1'b1;
        bus.data_wr   = 1'b1;
        bus.data_addr = 32'h8000_0200;
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_mem_req", {31'h0, bus.mem_req}, 32'h1);
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst_mem_req", {31'h0, bus.mem_req}, 32'h0);
        check("async_rst_data_ack", {31'h0, bus.data_ack}, 32'h0);
        bus.data_req = 1'b0;
        @(negedge clk);
        check("rst_hold_data_ack", {31'h0, bus.data_ack}, 32'h0);
        check("rst_hold_mem_addr", bus.mem_addr, 32'h0);
        resetn         = 1'b1;
        exp_inst_rdata = 32'h0;
        exp_data_rdata = 32'h0;
`ifdef ARB_ROUND_ROBIN_EN
        last_was_data  = 1'b0;
`endif
        run_round(1'b1, 32'h8000_0300, 1'b1, 1'b0, 4'h0, 32'h8000_0200, 32'h0, 1);

        // Randomized rounds.
        for (int i = 0; i < 40; i++) begin
            r = 2'($urandom_range(1, 3));
            run_round(r[0], $urandom, r[1], 1'($urandom), 4'($urandom), $urandom, $urandom,
                      int'($urandom_range(0, MAX_WAIT + 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
